// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and defaults for the HI/LO register controller.
//   state_t                 - controller FSM encoding
//   TIMEOUT_CYCLES_DEFAULT  - default cycle budget for a multiply/divide
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_MULT = 2'd1,
        RUN_DIV  = 2'd2
    } state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 40;

endpackage

// File: rtl/hilo_op_timer.sv
// op_timer: run-cycle counter with timeout compare.
//   clk     in   system clock
//   reset   in   synchronous active-high reset
//   clear   in   force the count to 0
//   enable  in   advance the count by one this cycle
//   expired out  count has reached TIMEOUT_CYCLES-1
module op_timer
    import hilo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences multiply/divide operations and owns the HI/LO registers.
//   clk, reset            clock and synchronous active-high reset
//   start_mult, start_div operation requests (ignored while busy)
//   mthi, mtlo, wdata     direct HI/LO writes (IDLE only)
//   mult_done, mult_hi/lo multiplier completion and result
//   div_done, div_zero,
//   div_hi/lo             divider completion, divide-by-zero flag, result
//   mult_init, div_init   unit run enables
//   busy                  stall request
//   hi, lo                architectural HI/LO
//   div_zero_exc          one-cycle divide-by-zero pulse
//   timeout_err           one-cycle abort pulse
//
// state    | meaning
// IDLE     | no operation; accepts starts and mthi/mtlo
// RUN_MULT | multiplier running, waiting for mult_done or timeout
// RUN_DIV  | divider running, waiting for div_zero/div_done or timeout
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        div_done,
    input  logic        div_zero,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        mult_init,
    output logic        div_init,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero_exc,
    output logic        timeout_err
);

    state_t      state, state_next;
    logic [31:0] hi_next, lo_next;
    logic        zero_exc_next, timeout_next;
    logic        expired;

    // Counter sits at 0 throughout IDLE, so every RUN_* entry starts from 0.
    op_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hi           <= '0;
            lo           <= '0;
            div_zero_exc <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_next;
            hi           <= hi_next;
            lo           <= lo_next;
            div_zero_exc <= zero_exc_next;
            timeout_err  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state;
        hi_next       = hi;
        lo_next       = lo;
        zero_exc_next = 1'b0;
        timeout_next  = 1'b0;
        case (state)
            IDLE: begin
                if (mthi) hi_next = wdata;
                if (mtlo) lo_next = wdata;
                if (start_div) begin
                    state_next = RUN_DIV;
                end else if (start_mult) begin
                    state_next = RUN_MULT;
                end
            end
            RUN_MULT: begin
                if (mult_done) begin
                    hi_next    = mult_hi;
                    lo_next    = mult_lo;
                    state_next = IDLE;
                end else if (expired) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            RUN_DIV: begin
                if (div_zero) begin
                    zero_exc_next = 1'b1;
                    state_next    = IDLE;
                end else if (div_done) begin
                    hi_next    = div_hi;
                    lo_next    = div_lo;
                    state_next = IDLE;
                end else if (expired) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign mult_init = (state == RUN_MULT);
    assign div_init  = (state == RUN_DIV);

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div, mthi, mtlo;
    logic [31:0] wdata;
    logic        mult_done, div_done, div_zero;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic        mult_init, div_init, busy, div_zero_exc, timeout_err;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int init_seen = 0;

    hilo_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start_mult  (start_mult),
        .start_div   (start_div),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .mult_done   (mult_done),
        .mult_hi     (mult_hi),
        .mult_lo     (mult_lo),
        .div_done    (div_done),
        .div_zero    (div_zero),
        .div_hi      (div_hi),
        .div_lo      (div_lo),
        .mult_init   (mult_init),
        .div_init    (div_init),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .div_zero_exc(div_zero_exc),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_mult = 0; start_div = 0; mthi = 0; mtlo = 0; wdata = '0;
        mult_done = 0; div_done = 0; div_zero = 0;
        mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
        step(); step();
        reset = 1'b0;

        // reset state
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mult_init", mult_init, 1'b0);
        chk1("rst_div_init", div_init, 1'b0);
        chk1("rst_dze", div_zero_exc, 1'b0);
        chk1("rst_to", timeout_err, 1'b0);
        chk32("rst_hi", hi, 32'h0);
        chk32("rst_lo", lo, 32'h0);

        // divide 100/7
        start_div = 1; step(); start_div = 0;
        chk1("div_busy", busy, 1'b1);
        chk1("div_div_init", div_init, 1'b1);
        chk1("div_mult_init", mult_init, 1'b0);
        step();
        div_done = 1; div_hi = 32'd2; div_lo = 32'd14; step(); div_done = 0;
        chk32("div_hi", hi, 32'd2);
        chk32("div_lo", lo, 32'd14);
        chk1("div_busy_after", busy, 1'b0);
        chk1("div_init_after", div_init, 1'b0);

        // multiply, div_init must stay low throughout
        init_seen = 0;
        start_mult = 1; step(); start_mult = 0;
        chk1("mul_mult_init", mult_init, 1'b1);
        if (div_init) init_seen++;
        step();
        if (div_init) init_seen++;
        mult_done = 1; mult_hi = 32'h1; mult_lo = 32'h0; step(); mult_done = 0;
        if (div_init) init_seen++;
        chk32("mul_hi", hi, 32'h1);
        chk32("mul_lo", lo, 32'h0);
        chk1("mul_busy_after", busy, 1'b0);
        chk32("mul_div_init_seen", 32'(init_seen), 32'd0);

        // divide by zero with HI preset; div_done also high to test priority
        mthi = 1; wdata = 32'hDEADBEEF; step(); mthi = 0;
        chk32("dz_preset_hi", hi, 32'hDEADBEEF);
        start_div = 1; step(); start_div = 0;
        div_zero = 1; div_done = 1; div_hi = 32'h5; div_lo = 32'h6; step();
        div_zero = 0; div_done = 0;
        chk1("dz_exc", div_zero_exc, 1'b1);
        chk32("dz_hi", hi, 32'hDEADBEEF);
        chk32("dz_lo", lo, 32'h0);
        chk1("dz_busy", busy, 1'b0);
        step();
        chk1("dz_exc_once", div_zero_exc, 1'b0);

        // timeout: 40 run cycles with no done
        start_mult = 1; step(); start_mult = 0;
        for (int i = 0; i < 39; i++) step();
        chk1("to_busy_39", busy, 1'b1);
        chk1("to_err_39", timeout_err, 1'b0);
        step();
        chk1("to_err", timeout_err, 1'b1);
        chk1("to_busy", busy, 1'b0);
        chk32("to_hi", hi, 32'hDEADBEEF);
        chk32("to_lo", lo, 32'h0);
        step();
        chk1("to_err_once", timeout_err, 1'b0);

        // done on the last budget cycle beats timeout
        start_mult = 1; step(); start_mult = 0;
        for (int i = 0; i < 39; i++) step();
        mult_done = 1; mult_hi = 32'hAAAA0000; mult_lo = 32'h00005555; step(); mult_done = 0;
        chk32("edge_hi", hi, 32'hAAAA0000);
        chk32("edge_lo", lo, 32'h00005555);
        chk1("edge_to", timeout_err, 1'b0);
        chk1("edge_busy", busy, 1'b0);

        // reset on cycle 5 of RUN_DIV, then a stray div_done
        start_div = 1; step(); start_div = 0;
        for (int i = 0; i < 4; i++) step();
        chk1("rmid_busy_pre", busy, 1'b1);
        reset = 1; step(); reset = 0;
        chk1("rmid_busy", busy, 1'b0);
        div_done = 1; div_hi = 32'h77; div_lo = 32'h88; step(); div_done = 0;
        chk32("rmid_hi", hi, 32'h0);
        chk32("rmid_lo", lo, 32'h0);
        chk1("rmid_dze", div_zero_exc, 1'b0);
        chk1("rmid_busy2", busy, 1'b0);
        chk1("rmid_div_init", div_init, 1'b0);

        // mthi while busy is ignored
        start_mult = 1; step(); start_mult = 0;
        mthi = 1; wdata = 32'h12345678; step(); mthi = 0;
        chk32("busy_mthi_hi", hi, 32'h0);
        chk1("busy_mthi_busy", busy, 1'b1);
        mult_done = 1; mult_hi = 32'h11; mult_lo = 32'h22; step(); mult_done = 0;
        chk32("busy_mthi_res", hi, 32'h11);

        // both starts: divide wins
        start_mult = 1; start_div = 1; step(); start_mult = 0; start_div = 0;
        chk1("both_div_init", div_init, 1'b1);
        chk1("both_mult_init", mult_init, 1'b0);
        div_done = 1; div_hi = 32'h3; div_lo = 32'h4; step(); div_done = 0;
        chk32("both_hi", hi, 32'h3);
        chk32("both_lo", lo, 32'h4);

        // mthi+mtlo together with start: write lands, result later overwrites
        mthi = 1; mtlo = 1; wdata = 32'hCAFE0000; start_mult = 1; step();
        mthi = 0; mtlo = 0; start_mult = 0;
        chk32("co_hi", hi, 32'hCAFE0000);
        chk32("co_lo", lo, 32'hCAFE0000);
        chk1("co_mult_init", mult_init, 1'b1);
        mult_done = 1; mult_hi = 32'h9; mult_lo = 32'h8; step(); mult_done = 0;
        chk32("co_res_hi", hi, 32'h9);
        chk32("co_res_lo", lo, 32'h8);

        // done/zero inputs in IDLE are ignored
        mult_done = 1; mult_hi = 32'hFFFF; div_zero = 1; div_done = 1; div_hi = 32'hEEEE; step();
        mult_done = 0; div_zero = 0; div_done = 0;
        chk32("idle_done_hi", hi, 32'h9);
        chk1("idle_done_dze", div_zero_exc, 1'b0);
        chk1("idle_done_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
